// File: rtl/axis_video_decim2.sv
// axis_video_decim2
//   2x2 decimator for an RGB565 AXI4-Stream video feed (TUSER = start of frame,
//   TLAST = end of line). Keeps pixels with even x on even lines and regenerates
//   TUSER/TLAST for the half-resolution output. Input framing is checked against
//   X_RES/Y_RES. On a mismatch the block drops beats until the next start of frame.
//
// Ports
//   i_pclk              pixel clock, all logic on rising edge
//   i_reset             synchronous active-high reset
//   i_enable            high: process stream; low: accept and drop all input
//   S_AXIS_VIDEO_*      input stream (TDATA/TVALID/TREADY/TUSER/TLAST)
//   M_AXIS_VIDEO_*      decimated output stream, single output register
//   o_sync_err          one-cycle pulse on a framing violation
//   o_frame_done        one-cycle pulse after the last beat of a full frame
module axis_video_decim2 #(
    parameter int unsigned X_RES = 640,
    parameter int unsigned Y_RES = 480
) (
    input  logic        i_pclk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [15:0] S_AXIS_VIDEO_TDATA,
    input  logic        S_AXIS_VIDEO_TVALID,
    output logic        S_AXIS_VIDEO_TREADY,
    input  logic        S_AXIS_VIDEO_TUSER,
    input  logic        S_AXIS_VIDEO_TLAST,
    output logic [15:0] M_AXIS_VIDEO_TDATA,
    output logic        M_AXIS_VIDEO_TVALID,
    input  logic        M_AXIS_VIDEO_TREADY,
    output logic        M_AXIS_VIDEO_TUSER,
    output logic        M_AXIS_VIDEO_TLAST,
    output logic        o_sync_err,
    output logic        o_frame_done
);

    localparam int unsigned XW = (X_RES > 1) ? $clog2(X_RES) : 1;
    localparam int unsigned YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;

    localparam logic [XW-1:0] X_LAST      = XW'(X_RES - 1);
    localparam logic [XW-1:0] X_KEEP_LAST = XW'(X_RES - 2);
    localparam logic [YW-1:0] Y_LAST      = YW'(Y_RES - 1);

    typedef enum logic [0:0] {
        StWaitSof,
        StActive
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [15:0]   r_m_tdata;
    logic          r_m_tvalid;
    logic          r_m_tuser;
    logic          r_m_tlast;
    logic          r_sync_err;
    logic          r_frame_done;

    logic w_accept;
    logic w_proc;
    logic w_origin;
    logic w_err;
    logic w_keep;
    logic w_eol;
    logic w_eof;

    // Ready never depends on S_TVALID; the only combinational input is M_TREADY.
    assign S_AXIS_VIDEO_TREADY = !i_reset &&
        (r_state == StWaitSof || !i_enable || !r_m_tvalid || M_AXIS_VIDEO_TREADY);

    assign w_accept = S_AXIS_VIDEO_TVALID && S_AXIS_VIDEO_TREADY;
    // In StWaitSof the counters are already zero, so a TUSER beat is handled
    // exactly like pixel (0,0) in StActive.
    assign w_proc   = w_accept && i_enable && (r_state == StActive || S_AXIS_VIDEO_TUSER);
    assign w_origin = (r_x == '0) && (r_y == '0);
    assign w_eol    = (r_x == X_LAST);
    assign w_eof    = w_eol && (r_y == Y_LAST);
    assign w_keep   = !r_x[0] && !r_y[0];
    assign w_err    = (S_AXIS_VIDEO_TLAST && !w_eol) ||
                      (!S_AXIS_VIDEO_TLAST && w_eol) ||
                      (S_AXIS_VIDEO_TUSER && !w_origin);

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state      <= StWaitSof;
            r_x          <= '0;
            r_y          <= '0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tuser    <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;

            // Drain first; a load below in the same cycle overrides this.
            if (r_m_tvalid && M_AXIS_VIDEO_TREADY) begin
                r_m_tvalid <= 1'b0;
            end

            if (!i_enable) begin
                r_state <= StWaitSof;
                r_x     <= '0;
                r_y     <= '0;
            end else if (w_proc) begin
                if (w_err) begin
                    r_sync_err <= 1'b1;
                    r_y        <= '0;
                    if (S_AXIS_VIDEO_TUSER) begin
                        // Misplaced start of frame: restart geometry on this beat.
                        r_m_tdata  <= S_AXIS_VIDEO_TDATA;
                        r_m_tvalid <= 1'b1;
                        r_m_tuser  <= 1'b1;
                        r_m_tlast  <= (X_KEEP_LAST == '0);
                        r_x        <= XW'(1);
                        r_state    <= StActive;
                    end else begin
                        r_x     <= '0;
                        r_state <= StWaitSof;
                    end
                end else begin
                    if (w_keep) begin
                        r_m_tdata  <= S_AXIS_VIDEO_TDATA;
                        r_m_tvalid <= 1'b1;
                        r_m_tuser  <= w_origin;
                        r_m_tlast  <= (r_x == X_KEEP_LAST);
                    end
                    if (w_eof) begin
                        r_frame_done <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_state      <= StWaitSof;
                    end else if (w_eol) begin
                        r_x     <= '0;
                        r_y     <= r_y + YW'(1);
                        r_state <= StActive;
                    end else begin
                        r_x     <= r_x + XW'(1);
                        r_state <= StActive;
                    end
                end
            end
        end
    end

    assign M_AXIS_VIDEO_TDATA  = r_m_tdata;
    assign M_AXIS_VIDEO_TVALID = r_m_tvalid;
    assign M_AXIS_VIDEO_TUSER  = r_m_tuser;
    assign M_AXIS_VIDEO_TLAST  = r_m_tlast;
    assign o_sync_err          = r_sync_err;
    assign o_frame_done        = r_frame_done;

endmodule

// File: tb/tb_axis_video_decim2.sv
// tb_axis_video_decim2
//   Directed scenario sequence with randomized valid/ready timing. Expected
//   output beats are derived from pixel coordinates (even x on even line kept).
module tb_axis_video_decim2;

    localparam int X = 8;
    localparam int Y = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tuser;
    logic        s_tlast;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tuser;
    logic        m_tlast;
    logic        sync_err;
    logic        frame_done;

    always #5 clk = ~clk;

    axis_video_decim2 #(
        .X_RES(X),
        .Y_RES(Y)
    ) dut (
        .i_pclk              (clk),
        .i_reset             (i_reset),
        .i_enable            (i_enable),
        .S_AXIS_VIDEO_TDATA  (s_tdata),
        .S_AXIS_VIDEO_TVALID (s_tvalid),
        .S_AXIS_VIDEO_TREADY (s_tready),
        .S_AXIS_VIDEO_TUSER  (s_tuser),
        .S_AXIS_VIDEO_TLAST  (s_tlast),
        .M_AXIS_VIDEO_TDATA  (m_tdata),
        .M_AXIS_VIDEO_TVALID (m_tvalid),
        .M_AXIS_VIDEO_TREADY (m_tready),
        .M_AXIS_VIDEO_TUSER  (m_tuser),
        .M_AXIS_VIDEO_TLAST  (m_tlast),
        .o_sync_err          (sync_err),
        .o_frame_done        (frame_done)
    );

    typedef struct packed {
        logic        en;
        logic        user;
        logic        last;
        logic [15:0] data;
    } beat_t;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [15:0] data;
    } obeat_t;

    beat_t  in_q[$];
    obeat_t exp_q[$];
    obeat_t got_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_in(input logic [15:0] d, input logic u, input logic l,
                                    input logic en);
        in_q.push_back('{en: en, user: u, last: l, data: d});
    endfunction

    function automatic void push_exp(input logic [15:0] d, input logic u, input logic l);
        exp_q.push_back('{user: u, last: l, data: d});
    endfunction

    // Beats at linear frame positions first..first+count-1 with correct framing.
    function automatic void add_range(input int first, input int count, input bit keep,
                                      input bit rnd);
        for (int p = first; p < first + count; p++) begin
            int          x;
            int          y;
            logic [15:0] d;
            x = p % X;
            y = p / X;
            d = rnd ? 16'($urandom) : {8'(y), 8'(x)};
            push_in(d, p == 0, x == X - 1, 1'b1);
            if (keep && (x % 2 == 0) && (y % 2 == 0)) push_exp(d, p == 0, x == X - 2);
        end
    endfunction

    task automatic run_seq(input string name, input int vld_pct, input int rdy_pct,
                           input int exp_err, input int exp_done);
        int     idx    = 0;
        int     tail   = 0;
        int     cyc    = 0;
        int     n_err  = 0;
        int     n_done = 0;
        int     n_bub  = 0;
        int     n_cmp;
        bit     stall  = 1'b0;
        obeat_t held   = '0;
        got_q.delete();
        while (tail < 20 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (idx < in_q.size()) begin
                s_tvalid = ($urandom_range(99) < vld_pct);
                i_enable = in_q[idx].en;
                s_tuser  = in_q[idx].user;
                s_tlast  = in_q[idx].last;
                s_tdata  = in_q[idx].data;
            end else begin
                s_tvalid = 1'b0;
                i_enable = 1'b1;
                s_tuser  = 1'b0;
                s_tlast  = 1'b0;
                tail++;
            end
            m_tready = ($urandom_range(99) < rdy_pct);
            #1;
            if (sync_err) n_err++;
            if (frame_done) n_done++;
            if (stall) check({name, ":stall_hold"}, {m_tvalid, m_tuser, m_tlast, m_tdata},
                             {1'b1, held});
            if (s_tvalid && s_tready) idx++;
            else if (s_tvalid) n_bub++;
            if (m_tvalid && m_tready) got_q.push_back('{user: m_tuser, last: m_tlast,
                                                       data: m_tdata});
            stall = m_tvalid && !m_tready;
            held  = '{user: m_tuser, last: m_tlast, data: m_tdata};
        end
        check({name, ":beats_accepted"}, idx, in_q.size());
        check({name, ":out_count"}, got_q.size(), exp_q.size());
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("%s:out%0d", name, i), got_q[i], exp_q[i]);
        end
        check({name, ":sync_err_pulses"}, n_err, exp_err);
        check({name, ":frame_done_pulses"}, n_done, exp_done);
        if (vld_pct >= 100 && rdy_pct >= 100) check({name, ":input_bubbles"}, n_bub, 0);
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst:m_tvalid", m_tvalid, 0);
        check("rst:m_tdata", m_tdata, 0);
        check("rst:m_tuser_tlast", {m_tuser, m_tlast}, 0);
        check("rst:pulses", {sync_err, frame_done}, 0);
        check("rst:s_tready", s_tready, 0);
        i_reset = 1'b0;
        #1;
        check("rst:s_tready_after", s_tready, 1);

        // Three clean back-to-back frames, full throughput
        for (int f = 0; f < 3; f++) add_range(0, X * Y, 1'b1, 1'b0);
        run_seq("clean3", 100, 100, 0, 3);

        // Same stream with random downstream stalls, plus a random-data frame
        for (int f = 0; f < 3; f++) add_range(0, X * Y, 1'b1, 1'b0);
        run_seq("stall3", 100, 50, 0, 3);
        add_range(0, X * Y, 1'b1, 1'b1);
        run_seq("randdata", 70, 50, 0, 1);

        // Early TLAST at x=5 of line 1; drop until next TUSER
        add_range(0, X + 5, 1'b1, 1'b0);
        push_in(16'h0105, 1'b0, 1'b1, 1'b1);
        add_range(X + 6, 10, 1'b0, 1'b0);
        add_range(0, X * Y, 1'b1, 1'b0);
        run_seq("tlast_err", 80, 100, 1, 1);

        // TUSER at x=4 of line 2 becomes the new pixel (0,0)
        add_range(0, 2 * X + 4, 1'b1, 1'b0);
        push_in(16'h0204, 1'b1, 1'b0, 1'b1);
        push_exp(16'h0204, 1'b1, 1'b0);
        add_range(1, X * Y - 1, 1'b1, 1'b0);
        run_seq("tuser_err", 80, 100, 1, 1);

        // Enable dropped mid-frame: partial frame abandoned without error
        add_range(0, 4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_in(16'($urandom), 1'b0, 1'b0, 1'b0);
        add_range(0, X * Y, 1'b1, 1'b0);
        run_seq("enable_off", 80, 100, 0, 1);

        // Reset while output is stalled
        @(negedge clk);
        m_tready = 1'b0;
        i_enable = 1'b1;
        s_tvalid = 1'b1;
        s_tuser  = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = 16'hABCD;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        #1;
        check("rststall:loaded", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b110, 16'hABCD});
        i_reset = 1'b1;
        #1;
        check("rststall:s_tready_in_reset", s_tready, 0);
        @(negedge clk);
        #1;
        check("rststall:outputs_cleared", {m_tvalid, m_tuser, m_tlast, m_tdata, sync_err,
                                           frame_done}, 0);
        check("rststall:s_tready_still_reset", s_tready, 0);
        i_reset = 1'b0;

        // After reset, stream begins mid-frame at line 2 pixel 3
        add_range(2 * X + 3, X * Y - (2 * X + 3), 1'b0, 1'b0);
        add_range(0, X * Y, 1'b1, 1'b0);
        run_seq("midframe", 100, 100, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
